// File: rtl/calc_core.sv
// calc_core: nibble-edited operands, single-cycle ALU/shift ops, iterative mul/div.
// Define CALC_SIGNED_MUL_EN to turn op F into a signed multiply.
module calc_core #(
  parameter  int WIDTH = 32,
  localparam int NIB   = WIDTH / 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NIB-1:0]     inc_pulse,
  input  logic               dec,
  input  logic               sel,
  input  logic [3:0]         op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   opa,
  output logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] result,
  output logic [2*WIDTH-1:0] last_result,
  output logic               zf,
  output logic               sf,
  output logic               cf,
  output logic               of,
  output logic               err
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]    p_q, p_d;
  logic [W2-1:0]    res_q, res_d, last_q, last_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic             zf_q, zf_d, sf_q, sf_d, cf_q, cf_d;
  logic             of_q, of_d, err_q, err_d, done_q, done_d;
`ifdef CALC_SIGNED_MUL_EN
  logic             sgn_q, sgn_d, neg_q, neg_d;
`endif

  logic [WIDTH:0]   add_w, sub_w, madd, dshl, ddif;
  logic [WIDTH-1:0] src, sra_w, mcand, ed;
  logic [SHW-1:0]   sh;
  logic [W2-1:0]    rot_w, alu_r, mstep, prod_n, dstep;
  logic             alu_cf, alu_of, dge, dz;
  logic             fin, fin_sf, fin_cf, fin_of, fin_err;
  logic [W2-1:0]    fin_r;

  function automatic logic [W2-1:0] zx(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

  always_comb begin
    sh     = opb_q[SHW-1:0];
    src    = res_q[WIDTH-1:0];
    add_w  = {1'b0, opa_q} + {1'b0, opb_q};
    sub_w  = {1'b0, opa_q} + {1'b0, ~opb_q} + {{WIDTH{1'b0}}, 1'b1};
    sra_w  = $signed(src) >>> sh;
    rot_w  = {src, src} << sh;
    alu_r  = '0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    unique case (op)
      4'h0: begin
        alu_r  = zx(add_w[WIDTH-1:0]);
        alu_cf = add_w[WIDTH];
        alu_of = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                 (add_w[WIDTH-1] != opa_q[WIDTH-1]);
      end
      4'h1: begin
        alu_r  = zx(sub_w[WIDTH-1:0]);
        alu_cf = sub_w[WIDTH];
        alu_of = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) &&
                 (sub_w[WIDTH-1] != opa_q[WIDTH-1]);
      end
      4'h4: alu_r = zx(opa_q & opb_q);
      4'h5: alu_r = zx(opa_q | opb_q);
      4'h6: alu_r = zx(~(opa_q | opb_q));
      4'h7: alu_r = zx(~opa_q);
      4'h8: alu_r = zx({{(WIDTH-1){1'b0}},
                        $signed(opa_q) < $signed(opb_q)});
      4'h9: alu_r = zx({{(WIDTH-1){1'b0}}, opa_q < opb_q});
      4'hA: alu_r = zx(src << sh);
      4'hB: alu_r = zx(src >> sh);
      4'hC: alu_r = zx(sra_w);
      4'hD: alu_r = zx(rot_w[W2-1:WIDTH]);
      4'hE: alu_r = zx(opa_q);
      default: alu_r = '0;
    endcase
  end

  // Shift-add multiply and restoring divide share the p register.
  always_comb begin
`ifdef CALC_SIGNED_MUL_EN
    mcand  = (sgn_q && opa_q[WIDTH-1]) ? -opa_q : opa_q;
`else
    mcand  = opa_q;
`endif
    madd   = {1'b0, p_q[W2-1:WIDTH]} + (p_q[0] ? {1'b0, mcand} : '0);
    mstep  = {madd, p_q[WIDTH-1:1]};
`ifdef CALC_SIGNED_MUL_EN
    prod_n = neg_q ? -mstep : mstep;
`else
    prod_n = mstep;
`endif
    dshl   = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
    ddif   = dshl - {1'b0, opb_q};
    dge    = ~ddif[WIDTH];
    dstep  = {dge ? ddif[WIDTH-1:0] : dshl[WIDTH-1:0],
              p_q[WIDTH-2:0], dge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    last_d  = last_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    cf_d    = cf_q;
    of_d    = of_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef CALC_SIGNED_MUL_EN
    sgn_d   = sgn_q;
    neg_d   = neg_q;
`endif
    fin     = 1'b0;
    fin_r   = res_q;
    fin_sf  = 1'b0;
    fin_cf  = 1'b0;
    fin_of  = 1'b0;
    fin_err = 1'b0;
    ed      = sel ? opb_q : opa_q;
    dz      = (opb_q == '0);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            op == 4'h2: begin
              state_d = S_MUL;
              cnt_d   = '0;
              p_d     = zx(opb_q);
`ifdef CALC_SIGNED_MUL_EN
              sgn_d   = 1'b0;
              neg_d   = 1'b0;
`endif
            end
            op == 4'h3 && !dz: begin
              state_d = S_DIV;
              cnt_d   = '0;
              p_d     = zx(opa_q);
            end
            op == 4'h3 && dz: begin
              fin     = 1'b1;
              fin_r   = {{WIDTH{1'b1}}, opa_q};
              fin_sf  = opa_q[WIDTH-1];
              fin_err = 1'b1;
            end
`ifdef CALC_SIGNED_MUL_EN
            op == 4'hF: begin
              state_d = S_MUL;
              cnt_d   = '0;
              sgn_d   = 1'b1;
              neg_d   = opa_q[WIDTH-1] ^ opb_q[WIDTH-1];
              p_d     = zx(opb_q[WIDTH-1] ? -opb_q : opb_q);
            end
`else
            op == 4'hF: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
`endif
            default: begin
              fin    = 1'b1;
              fin_r  = alu_r;
              fin_sf = alu_r[WIDTH-1];
              fin_cf = alu_cf;
              fin_of = alu_of;
            end
          endcase
        end else begin
          for (int i = 0; i < NIB; i++) begin
            if (inc_pulse[i]) begin
              ed[4*i +: 4] = dec ? ed[4*i +: 4] - 4'd1
                                 : ed[4*i +: 4] + 4'd1;
            end
          end
          if (sel) opb_d = ed;
          else     opa_d = ed;
        end
      end
      S_MUL: begin
        p_d   = mstep;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          fin     = 1'b1;
          fin_r   = prod_n;
          fin_sf  = prod_n[W2-1];
        end
      end
      S_DIV: begin
        p_d   = dstep;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          fin     = 1'b1;
          fin_r   = {dstep[WIDTH-1:0], dstep[W2-1:WIDTH]};
          fin_sf  = dstep[W2-1];
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      done_d = 1'b1;
      last_d = res_q;
      res_d  = fin_r;
      zf_d   = (fin_r == '0);
      sf_d   = fin_sf;
      cf_d   = fin_cf;
      of_d   = fin_of;
      err_d  = fin_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      last_q  <= '0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef CALC_SIGNED_MUL_EN
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      last_q  <= last_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef CALC_SIGNED_MUL_EN
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign opa         = opa_q;
  assign opb         = opb_q;
  assign result      = res_q;
  assign last_result = last_q;
  assign zf          = zf_q;
  assign sf          = sf_q;
  assign cf          = cf_q;
  assign of          = of_q;
  assign err         = err_q;
endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core (WIDTH=32).
// Expected results are queued at start and checked when done pulses.
module tb_calc_core;
  localparam int W = 32;

  logic          clk, rst, dec, sel, start;
  logic [7:0]    inc_pulse;
  logic [3:0]    op;
  logic          busy, done, zf, sf, cf, of, err;
  logic [W-1:0]  opa, opb;
  logic [63:0]   result, last_result;

  calc_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .inc_pulse(inc_pulse), .dec(dec),
    .sel(sel), .op(op), .start(start), .busy(busy), .done(done),
    .opa(opa), .opb(opb), .result(result),
    .last_result(last_result), .zf(zf), .sf(sf), .cf(cf),
    .of(of), .err(err)
  );

  typedef struct {
    logic [63:0] res;
    logic [63:0] last;
    logic [4:0]  fl;
    int          lat;
    int          c0;
  } exp_t;

  exp_t        sb[$];
  int          n_vec, n_err, cyc;
  logic [31:0] ma, mb;
  logic [63:0] m_res, m_last;
  logic [4:0]  m_fl;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o);
    exp_t        e;
    logic [32:0] t;
    logic [63:0] r;
    logic [31:0] x;
    int          s;
    logic        c, v, er, rsv, mul;
    x = m_res[31:0];
    s = int'(mb[4:0]);
    r = '0; c = 0; v = 0; er = 0; rsv = 0; mul = 0;
    e.lat = 1;
    e.c0  = 0;
    case (o)
      4'h0: begin
        t = {1'b0, ma} + {1'b0, mb};
        r = {32'b0, t[31:0]};
        c = t[32];
        v = (ma[31] == mb[31]) && (t[31] != ma[31]);
      end
      4'h1: begin
        t = {1'b0, ma} - {1'b0, mb};
        r = {32'b0, t[31:0]};
        c = (ma >= mb);
        v = (ma[31] != mb[31]) && (t[31] != ma[31]);
      end
      4'h2: begin
        r = {32'b0, ma} * {32'b0, mb};
        e.lat = W + 1;
        mul = 1;
      end
      4'h3: begin
        if (mb == 0) begin
          r = {32'hFFFF_FFFF, ma};
          er = 1;
        end else begin
          r = {ma / mb, ma % mb};
          e.lat = W + 1;
        end
      end
      4'h4: r = {32'b0, ma & mb};
      4'h5: r = {32'b0, ma | mb};
      4'h6: r = {32'b0, ~(ma | mb)};
      4'h7: r = {32'b0, ~ma};
      4'h8: r = {63'b0, $signed(ma) < $signed(mb)};
      4'h9: r = {63'b0, ma < mb};
      4'hA: r = {32'b0, x << s};
      4'hB: r = {32'b0, x >> s};
      4'hC: r = {32'b0, 32'($signed(x) >>> s)};
      4'hD: r = {32'b0, (s == 0) ? x : ((x << s) | (x >> (32 - s)))};
      4'hE: r = {32'b0, ma};
      default: begin
`ifdef CALC_SIGNED_MUL_EN
        r = 64'($signed({{32{ma[31]}}, ma}) *
                $signed({{32{mb[31]}}, mb}));
        e.lat = W + 1;
        mul = 1;
`else
        rsv = 1;
`endif
      end
    endcase
    if (rsv) begin
      e.res  = m_res;
      e.last = m_last;
      e.fl   = {m_fl[4:1], 1'b1};
    end else begin
      e.res  = r;
      e.last = m_res;
      e.fl   = {r == 64'd0, mul ? r[63] : r[31], c, v, er};
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("last_result", last_result, e.last);
        chk("flags_zscoe", 64'({zf, sf, cf, of, err}), 64'(e.fl));
        chk("latency", 64'(cyc - e.c0), 64'(e.lat));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic pulse(input logic [7:0] m, input logic d);
    @(negedge clk);
    inc_pulse = m;
    dec = d;
    @(negedge clk);
    inc_pulse = '0;
    dec = 1'b0;
  endtask

  task automatic set_opnd(input logic s, input logic [31:0] v);
    logic [31:0] cur;
    logic [7:0]  m;
    cur = s ? mb : ma;
    sel = s;
    dec = 1'b0;
    for (int k = 0; k < 16; k++) begin
      m = '0;
      for (int i = 0; i < 8; i++) begin
        if (cur[4*i +: 4] != v[4*i +: 4]) begin
          m[i] = 1'b1;
          cur[4*i +: 4] = cur[4*i +: 4] + 4'd1;
        end
      end
      if (m == '0) break;
      @(negedge clk);
      inc_pulse = m;
    end
    @(negedge clk);
    inc_pulse = '0;
    if (s) mb = v;
    else   ma = v;
    chk(s ? "opb_set" : "opa_set", 64'(s ? opb : opa), 64'(v));
  endtask

  task automatic do_op(input logic [3:0] o, input bit poke,
                       input logic [7:0] inc_w);
    exp_t e;
    e = model(o);
    @(negedge clk);
    op = o;
    start = 1'b1;
    inc_pulse = inc_w;
    dec = 1'b0;
    e.c0 = cyc;
    sb.push_back(e);
    m_res = e.res;
    m_last = e.last;
    m_fl = e.fl;
    @(negedge clk);
    start = 1'b0;
    inc_pulse = '0;
    if (poke) begin
      repeat (4) @(negedge clk);
      chk("busy_mid", 64'(busy), 64'd1);
      start = 1'b1;
      op = 4'h0;
      inc_pulse = '1;
      @(negedge clk);
      start = 1'b0;
      inc_pulse = '0;
    end
    for (int k = 0; k < 80 && sb.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      chk("done_timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] o);
    set_opnd(1'b0, a);
    set_opnd(1'b1, b);
    do_op(o, 1'b0, 8'h00);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    ma = '0; mb = '0; m_res = '0; m_last = '0; m_fl = '0;
    rst = 1'b1; dec = 1'b0; sel = 1'b0; start = 1'b0;
    inc_pulse = '0; op = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_result", result, 64'd0);
    chk("rst_last", last_result, 64'd0);
    chk("rst_opa_opb", {opa, opb}, 64'd0);
    chk("rst_status", 64'({busy, done, zf, sf, cf, of, err}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    sel = 1'b0;
    repeat (3) pulse(8'h01, 1'b0);
    chk("nib_inc", 64'(opa), 64'h3);
    pulse(8'h80, 1'b1);
    chk("nib_dec_wrap", 64'(opa), 64'hF000_0003);
    pulse(8'h81, 1'b0);
    chk("nib_multi", 64'(opa), 64'h4);
    chk("nib_opb_kept", 64'(opb), 64'h0);
    ma = 32'h4;

    do_op(4'hE, 1'b0, 8'h01);
    chk("edit_with_start", 64'(opa), 64'h4);

    set_op(32'h7FFF_FFFF, 32'h1, 4'h0);
    set_opnd(1'b0, 32'hFFFF_FFFF);
    set_opnd(1'b1, 32'h2);
    do_op(4'h2, 1'b1, 8'h00);
    chk("frozen_opa", 64'(opa), 64'(ma));
    chk("frozen_opb", 64'(opb), 64'(mb));

    set_op(32'd100, 32'd7, 4'h3);
    set_op(32'd100, 32'd0, 4'h3);
    set_op(32'h3, 32'h3, 4'h1);
    set_op(32'h8000_0000, 32'h4, 4'hE);
    do_op(4'hC, 1'b0, 8'h00);
    do_op(4'hD, 1'b0, 8'h00);
    set_op(32'hFFFF_FFFD, 32'h5, 4'hF);
    set_op(32'hFFFF_FFFD, 32'h5, 4'h8);
    do_op(4'h9, 1'b0, 8'h00);

    for (int k = 0; k < 20; k++) begin
      logic [31:0] a, b;
      logic [3:0]  o;
      a = $urandom;
      b = (k % 6 == 0) ? 32'd0 : $urandom;
      o = 4'($urandom_range(0, 14));
      set_op(a, b, o);
    end

    set_opnd(1'b0, 32'h1234_5678);
    set_opnd(1'b1, 32'h9);
    @(negedge clk);
    op = 4'h2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_status", 64'({busy, done, zf, sf, cf, of, err}), 64'd0);
    chk("arst_result", result, 64'd0);
    chk("arst_last", last_result, 64'd0);
    chk("arst_opa_opb", {opa, opb}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ma = '0; mb = '0; m_res = '0; m_last = '0; m_fl = '0;
    repeat (40) @(negedge clk);
    set_op(32'h5, 32'h0, 4'hE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
